// File: rtl/display_plotter.sv
// rtl/display_plotter.sv - diff-aware 16x32 bitmap to VGA-adapter pixel plotter
//
// Ports:
//   clock          system clock
//   resetn         synchronous active-low reset
//   start          frame request pulse, accepted only when idle
//   force_full     sampled with start: 1 plots every pixel, 0 plots changed pixels
//   display        bitmap, pixel (x,y) = display[32*x + y]
//   x, y, colour   registered pixel address and colour to the VGA adapter
//   plot           registered write strobe to the VGA adapter
//   busy           high from start acceptance until done
//   done           one-cycle pulse after the last pixel
//   plotted_count  plot strobes issued in the current/last frame
module display_plotter #(
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic         force_full,
  input  logic [511:0] display,
  output logic [3:0]   x,
  output logic [4:0]   y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         done,
  output logic [9:0]   plotted_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [511:0] snapshot;
  logic [511:0] shadow;
  logic         mode_full;
  // idx equals 32*x + y, so it addresses the bitmap directly and its
  // upper/lower bits are the x/y coordinates of the pixel being processed.
  logic [8:0]   idx;

  logic         snap_bit;
  logic         shadow_bit;
  logic         pix_plot;
  logic         accept;
  logic         scan_step;

  logic [3:0]   x_nxt;
  logic [4:0]   y_nxt;
  logic [2:0]   colour_nxt;
  logic         plot_nxt;
  logic         busy_nxt;
  logic         done_nxt;
  logic [9:0]   count_nxt;

  assign snap_bit   = snapshot[idx];
  assign shadow_bit = shadow[idx];
  assign pix_plot   = mode_full | (snap_bit ^ shadow_bit);
  assign accept     = (state == IDLE) && start;
  assign scan_step  = (state == SCAN);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (idx == 9'd511) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    colour_nxt = colour;
    plot_nxt   = 1'b0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    count_nxt  = plotted_count;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt  = 1'b1;
          count_nxt = 10'd0;
        end
      end
      SCAN: begin
        x_nxt      = idx[8:5];
        y_nxt      = idx[4:0];
        colour_nxt = snap_bit ? FG_COLOUR : BG_COLOUR;
        plot_nxt   = pix_plot;
        if (pix_plot) count_nxt = plotted_count + 10'd1;
      end
      FIN: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x             <= 4'd0;
      y             <= 5'd0;
      colour        <= BG_COLOUR;
      plot          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      plotted_count <= 10'd0;
      snapshot      <= '0;
      shadow        <= '0;
      mode_full     <= 1'b0;
      idx           <= 9'd0;
    end else begin
      x             <= x_nxt;
      y             <= y_nxt;
      colour        <= colour_nxt;
      plot          <= plot_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      plotted_count <= count_nxt;
      if (accept) begin
        snapshot  <= display;
        mode_full <= force_full;
        idx       <= 9'd0;
      end
      if (scan_step) begin
        shadow[idx] <= snap_bit;
        // Wraps to 0 after the terminal pixel; idx is reloaded on the next
        // accept anyway, so the wrap is never observed inside a frame.
        idx         <= idx + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_plotter.sv
// tb/tb_display_plotter.sv - scoreboard bench for display_plotter
module tb_display_plotter;

  logic         clock;
  logic         resetn;
  logic         start;
  logic         force_full;
  logic [511:0] display;
  logic [3:0]   x;
  logic [4:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;
  logic [9:0]   plotted_count;

  display_plotter dut (
    .clock(clock), .resetn(resetn), .start(start), .force_full(force_full),
    .display(display), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .plotted_count(plotted_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } strobe_t;

  typedef struct {
    int cyc;
    int count;
  } done_t;

  strobe_t sq[$];
  done_t   dq[$];
  bit [511:0] m_shadow;
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: a frame is the list of pixels that differ from the
  // previous frame (or all of them in full mode), in y-then-x order.
  task automatic model_frame(input logic [511:0] d, input logic ff, input int s);
    int cnt;
    strobe_t e;
    done_t   de;
    cnt = 0;
    for (int k = 0; k < 512; k++) begin
      if (ff || (d[k] != m_shadow[k])) begin
        e.cyc = s + k + 1;
        e.x   = k / 32;
        e.y   = k % 32;
        e.col = d[k] ? 7 : 0;
        sq.push_back(e);
        cnt++;
      end
      m_shadow[k] = d[k];
    end
    de.cyc   = s + 513;
    de.count = cnt;
    dq.push_back(de);
  endtask

  // Monitor: compares every strobe / done pulse against the queues.
  always @(negedge clock) begin
    if (plot) begin
      if (sq.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        strobe_t e;
        e = sq.pop_front();
        check("plot_cycle", cyc, e.cyc);
        check("plot_xyc", {x, y, colour}, {e.x[3:0], e.y[4:0], e.col[2:0]});
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        done_t de;
        de = dq.pop_front();
        check("done_cycle", cyc, de.cyc);
        check("plotted_count", int'(plotted_count), de.count);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Issue a start that the DUT is expected to accept; s is its edge number.
  task automatic issue_start(input logic [511:0] d, input logic ff, output int s);
    display    = d;
    force_full = ff;
    start      = 1'b1;
    s          = cyc + 1;
    model_frame(d, ff, s);
    step();
    start      = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    display    = rand512();
    force_full = 1'($urandom);
  endtask

  task automatic full_frame(input logic [511:0] d, input logic ff);
    int s;
    issue_start(d, ff, s);
    wait_until(s + 512);
    check("busy_last_pixel", int'(busy), 1);
    wait_until(s + 513);
    check("busy_at_done", {busy, done}, 2'b01);
    wait_until(s + 514);
    check("done_cleared", int'(done), 0);
  endtask

  initial begin
    int s;
    int rc;
    logic [511:0] d;
    resetn     = 1'b0;
    start      = 1'b0;
    force_full = 1'b0;
    display    = '0;
    m_shadow   = '0;
    repeat (3) step();
    // Reset held together with start: reset wins.
    start = 1'b1;
    step();
    start = 1'b0;
    check("reset_outputs", {x, y, colour, plot, busy, done, plotted_count},
          {4'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0});
    resetn = 1'b1;
    step();

    // 1: blank frame, diff mode
    full_frame('0, 1'b0);
    // 2: corners set
    d = '0; d[0] = 1'b1; d[511] = 1'b1;
    full_frame(d, 1'b0);
    // 3: (0,0) cleared, (3,5) set, (15,31) kept
    d = '0; d[32*3 + 5] = 1'b1; d[511] = 1'b1;
    full_frame(d, 1'b0);
    // 4: full mode
    full_frame(rand512(), 1'b1);

    // 5: starts while busy are ignored; the one at E514 is accepted
    issue_start(rand512(), 1'b0, s);
    wait_until(s + 99);
    display = rand512(); force_full = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_until(s + 512);
    display = rand512(); force_full = 1'b1; start = 1'b1;
    step();
    check("busy_at_done_cycle", {busy, done}, 2'b01);
    start = 1'b0;
    full_frame(rand512(), 1'b1);

    // random frames
    for (int i = 0; i < 4; i++) full_frame(rand512(), 1'($urandom_range(0, 3) == 0));

    // 6: reset mid-scan at E200
    issue_start(rand512(), 1'b0, s);
    wait_until(s + 199);
    resetn = 1'b0;
    rc = s + 200;
    while (sq.size() > 0 && sq[sq.size()-1].cyc >= rc) void'(sq.pop_back());
    dq.delete();
    m_shadow = '0;
    step();
    check("reset_mid_scan", {plot, busy, done, plotted_count}, {1'b0, 1'b0, 1'b0, 10'd0});
    step();
    check("reset_hold", {plot, busy}, 2'b00);
    resetn = 1'b1;
    step();
    full_frame(rand512(), 1'b0);

    repeat (4) step();
    check("strobes_outstanding", sq.size(), 0);
    check("dones_outstanding", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/display_plotter.md
Name: display_plotter

Overview:
- Downstream consumer of the game state's 16x32 `display` bitmap.
- On each `start` pulse, snapshots the bitmap and walks all 512 pixels, one per clock. It drives `x`/`y`/`colour`/`plot` straight into the VGA adapter (RESOLUTION "16x32", 3-bit colour).
- A shadow copy of the last frame is kept, so by default only changed pixels are plotted.
- Replaces the free-running x/y counter scan in the current datapath.

Parameters:
- FG_COLOUR, 3'b111, colour written for a set bit (1).
- BG_COLOUR, 3'b000, colour written for a clear bit (0).

Ports:
- clock  input  1  system clock (CLOCK_50).
- resetn  input  1  synchronous, active-low reset; sampled on posedge clock only.
- start  input  1  frame request; one-cycle pulse, typically the game tick (delay_out).
- force_full  input  1  sampled with start; 1 = plot every pixel, 0 = plot changed pixels only.
- display  input  512  bitmap; pixel (x,y) = display[32*x + y], x 0..15, y 0..31.
- x  output  4  pixel column to VGA adapter.
- y  output  5  pixel row to VGA adapter.
- colour  output  3  pixel colour to VGA adapter.
- plot  output  1  write strobe to VGA adapter.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at frame completion.
- plotted_count  output  10  number of plot strobes issued in the current/last frame (0..512).

Behaviour:
- Clock and reset: one clock domain ("clock"). Reset is synchronous and active-low ("resetn").
- Reset values:
  - state = IDLE; x = 0, y = 0; colour = BG_COLOUR; plot = 0; busy = 0; done = 0; plotted_count = 0.
  - snapshot = 0; shadow = 0 (all black, matching the adapter's black.mif background after the shared reset).
- State machine: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - start = 1 at edge E0: latch display into snapshot, latch force_full into a mode register, index = 0, plotted_count = 0, busy = 1, go to SCAN.
  - start = 0: outputs hold, plot = 0.
- SCAN, edges E1..E512: at edge E(k+1), pixel k is processed.
  - Scan order: y inner, x outer, i.e. x = k / 32, y = k % 32 (same order as the existing y-then-x counters).
  - Registered outputs x, y take that pixel's coordinates; colour = FG_COLOUR if the snapshot bit is 1, else BG_COLOUR.
  - plot = 1 iff mode_full = 1 OR snapshot bit != shadow bit. Otherwise plot = 0 (x, y, colour still update).
  - The shadow bit is updated to the snapshot bit. plotted_count increments when plot = 1.
  - At the edge handling x = 15, y = 31, go to DONE.
- DONE, edge E513: plot = 0, done = 1, busy = 0, go to IDLE. done returns to 0 at E514 unless reset.
- Latency and throughput:
  - The first pixel strobe is visible one cycle after start is sampled.
  - The frame is always 512 cycles regardless of mode. done follows 513 cycles after start.
  - Minimum start-to-start spacing is 514 cycles.
- Boundary conditions:
  - start while busy (SCAN or DONE) is ignored: no re-latch, no queueing.
  - start in the same cycle done is high is accepted (state is IDLE only after E513, so start at E514 or later).
  - Changes on display during SCAN have no effect; only the snapshot is used.
  - force_full changes during SCAN have no effect.
  - Index wrap: the y counter wraps 31 -> 0 and carries into x. x = 15, y = 31 is terminal; no wrap to (0,0) inside a frame.
  - Reset mid-SCAN: all state returns to reset values on that edge, shadow is cleared, and no further plot strobes occur.
  - resetn low together with start: reset wins.
- plot is never asserted outside SCAN.

Test Plan:
1. Reset, then start with display = 0 and force_full = 0 -> 512 SCAN cycles with plot = 0 throughout; done pulses at E513; plotted_count = 0; busy high E0..E512.
2. Bits (x=0,y=0) and (x=15,y=31) set, force_full = 0 -> exactly 2 plot strobes: at E1 (x=0, y=0, colour=7) and at E512 (x=15, y=31, colour=7); plotted_count = 2.
3. Next frame with (0,0) cleared, (3,5) set, (15,31) kept -> strobes at E1 (0,0, colour=0) and E102 (3,5, colour=7); none at (15,31); plotted_count = 2.
4. start with force_full = 1 and any display -> 512 consecutive plot strobes in y-then-x order; colours match the bits; plotted_count = 512.
5. start re-asserted at E100 and at the E513 done cycle -> both ignored; a start at E514 is accepted (busy rises at E514, first strobe at E515).
6. resetn low at E200 mid-scan -> plot = 0 from E200; busy, done and plotted_count = 0. A subsequent diff-mode start re-plots all set pixels (shadow cleared).
